// File: rtl/alba_control.sv
// Multi-cycle control FSM for the albaCore 16-bit CPU.
// Sequences fetch/decode/execute/memory and drives every datapath strobe and the ALU function select.
module alba_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ir,
  input  logic        neg,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic [3:0]  rd_addr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        mar_we,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        fault
);

  // state     | meaning
  // S_FETCH   | instruction read at PC; on ready load IR and PC<=PC+1
  // S_DECODE  | register reads settle; halt opcode diverts to S_HALT
  // S_EXECUTE | ALU op / address calc / branch resolution
  // S_MEM     | data read or write at MAR
  // S_HALT    | halt executed, parked until reset
  // S_FAULT   | memory timeout, parked until reset
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam bit         TO_EN   = (MEM_TIMEOUT != 0);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;
  logic       req_active;
  logic       expire;

  assign opcode  = ir[15:12];
  assign ra_addr = ir[7:4];
  assign rb_addr = ir[3:0];
  assign rd_addr = ir[11:8];

  assign req_active = reset_n && (state == S_FETCH || state == S_MEM);
  // A ready on the last allowed cycle completes the request instead of faulting.
  assign expire     = TO_EN && req_active && !mem_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (!req_active || mem_ready)
        wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_op    = 4'd0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    mar_we    = 1'b0;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    // Strobes are held low while reset is asserted so a request in flight drops immediately.
    if (reset_n) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            alu_op    = 4'd10;
            state_nxt = S_DECODE;
          end else if (expire) begin
            state_nxt = S_FAULT;
          end
        end
        S_DECODE: begin
          state_nxt = (opcode == 4'd15) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          state_nxt = S_FETCH;
          unique case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              alu_op = opcode;
              rf_we  = 1'b1;
            end
            4'd8, 4'd9: begin
              alu_op    = opcode;
              mar_we    = 1'b1;
              state_nxt = S_MEM;
            end
            4'd10: begin
              alu_op = 4'd11;
              pc_we  = 1'b1;
            end
            4'd11: begin
              alu_op = 4'd11;
              pc_we  = zero;
            end
            4'd12: begin
              alu_op = 4'd11;
              pc_we  = neg;
            end
            4'd13: begin
              alu_op = 4'd12;
              pc_we  = 1'b1;
            end
            4'd14: begin
              alu_op = 4'd13;
              pc_we  = 1'b1;
            end
            default: state_nxt = S_HALT;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == 4'd9);
          if (mem_ready) begin
            if (opcode == 4'd8) begin
              rf_we  = 1'b1;
              wb_sel = 1'b1;
            end
            state_nxt = S_FETCH;
          end else if (expire) begin
            state_nxt = S_FAULT;
          end
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alba_control.sv
// Self-checking bench for alba_control: per-instruction cycle traces built from the instruction
// semantics, driven with random wait states, flags and stray ready pulses.
module tb_alba_control;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        neg = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0]  alu_op, ra_addr, rb_addr, rd_addr;
  logic        rf_we, wb_sel, ir_we, pc_we, mar_we, addr_sel, mem_req, mem_we, halted, fault;

  int checks = 0;
  int errors = 0;

  alba_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .neg(neg), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .rf_we(rf_we), .wb_sel(wb_sel), .ir_we(ir_we), .pc_we(pc_we), .mar_we(mar_we),
    .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // One expected clock cycle: inputs to drive plus the outputs the machine must show.
  typedef struct {
    logic        rdy, ng, zr;
    logic [15:0] irv;
    logic [3:0]  alu;
    logic        rf, wb, irw, pcw, marw, asel, req, we, h, f;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] cur_ir = 16'h0000;

  function automatic cyc_t idle(input logic [15:0] irv);
    cyc_t c;
    c.rdy = 1'($urandom); c.ng = 1'($urandom); c.zr = 1'($urandom);
    c.irv = irv; c.alu = 4'd0;
    c.rf = 0; c.wb = 0; c.irw = 0; c.pcw = 0; c.marw = 0;
    c.asel = 0; c.req = 0; c.we = 0; c.h = 0; c.f = 0;
    return c;
  endfunction

  // fw/mw = wait cycles before ready; fl < 0 random flags, else {neg,zero} in execute
  function automatic void gen(input logic [15:0] instr, input int fw, input int mw, input int fl);
    cyc_t c;
    int   op = int'(instr[15:12]);
    for (int i = 0; i < fw; i++) begin
      c = idle(cur_ir); c.rdy = 0; c.req = 1; q.push_back(c);
    end
    c = idle(cur_ir); c.rdy = 1; c.req = 1; c.irw = 1; c.pcw = 1; c.alu = 4'd10; q.push_back(c);
    cur_ir = instr;
    c = idle(instr); q.push_back(c);
    if (op == 15) begin
      for (int i = 0; i < 3; i++) begin
        c = idle(instr); c.h = 1; q.push_back(c);
      end
      return;
    end
    c = idle(instr);
    if (fl >= 0) begin c.ng = fl[1]; c.zr = fl[0]; end
    if (op <= 7)                 begin c.alu = 4'(op); c.rf = 1; end
    else if (op == 8 || op == 9) begin c.alu = 4'(op); c.marw = 1; end
    else if (op == 10)           begin c.alu = 4'd11; c.pcw = 1; end
    else if (op == 11)           begin c.alu = 4'd11; c.pcw = c.zr; end
    else if (op == 12)           begin c.alu = 4'd11; c.pcw = c.ng; end
    else if (op == 13)           begin c.alu = 4'd12; c.pcw = 1; end
    else                         begin c.alu = 4'd13; c.pcw = 1; end
    q.push_back(c);
    if (op == 8 || op == 9) begin
      for (int i = 0; i < mw; i++) begin
        c = idle(instr); c.rdy = 0; c.req = 1; c.asel = 1; c.we = (op == 9); q.push_back(c);
      end
      c = idle(instr); c.rdy = 1; c.req = 1; c.asel = 1; c.we = (op == 9);
      c.rf = (op == 8); c.wb = (op == 8);
      q.push_back(c);
    end
  endfunction

  task automatic run_q(input string tag);
    cyc_t        c;
    logic [13:0] exp_o, act_o;
    int          n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.irv; neg = c.ng; zero = c.zr; mem_ready = c.rdy;
      @(negedge clk);
      exp_o = {c.alu, c.rf, c.wb, c.irw, c.pcw, c.marw, c.asel, c.req, c.we, c.h, c.f};
      act_o = {alu_op, rf_we, wb_sel, ir_we, pc_we, mar_we, addr_sel, mem_req, mem_we, halted, fault};
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL %s cycle %0d ir=%h outputs got %b expected %b", tag, n, c.irv, act_o, exp_o);
      end
      checks++;
      if ({ra_addr, rb_addr, rd_addr} !== {c.irv[7:4], c.irv[3:0], c.irv[11:8]}) begin
        errors++;
        $display("FAIL %s_addr cycle %0d got %h expected %h", tag, n,
                 {ra_addr, rb_addr, rd_addr}, {c.irv[7:4], c.irv[3:0], c.irv[11:8]});
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cur_ir = ir;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({alu_op, rf_we, wb_sel, ir_we, pc_we, mar_we, addr_sel, mem_req, mem_we, halted, fault} !== 14'd0) begin
        errors++;
        $display("FAIL reset cycle %0d outputs got %b expected 0", i,
                 {alu_op, rf_we, wb_sel, ir_we, pc_we, mar_we, addr_sel, mem_req, mem_we, halted, fault});
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cur_ir = ir;
  endtask

  task automatic test_alu();
    gen(16'h0312, 0, 0, -1);
    run_q("alu_add");
  endtask

  task automatic test_branch();
    gen(16'hB005, 0, 0, 1);  // bz, zero=1: taken
    gen(16'hB005, 0, 0, 0);  // bz, zero=0: not taken
    gen(16'hC0F0, 0, 0, 2);  // bn, neg=1: taken
    gen(16'hC0F0, 1, 0, 1);  // bn, neg=0 zero=1: not taken
    gen(16'hA123, 0, 0, -1);
    run_q("branch");
  endtask

  task automatic test_ld();
    gen(16'h8542, 0, 2, -1);
    run_q("ld_wait2");
  endtask

  task automatic test_st();
    gen(16'h9A31, 1, 1, -1);
    run_q("st");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic [15:0] instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      gen(instr, 0, 0, -1);
    end
    run_q("back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [15:0] instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      gen(instr, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), -1);
      run_q("random");
    end
  endtask

  task automatic test_halt();
    gen(16'hF000, 0, 0, -1);
    run_q("halt");
    do_reset();
  endtask

  task automatic test_fault();
    do_reset();
    for (int i = 0; i < TO; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, fault} !== 2'b10) begin
        errors++;
        $display("FAIL fault_wait cycle %0d req/fault got %b expected 10", i, {mem_req, fault});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({mem_req, fault, ir_we, pc_we} !== 4'b0100) begin
        errors++;
        $display("FAIL fault_sticky cycle %0d req/fault/ir_we/pc_we got %b expected 0100", i,
                 {mem_req, fault, ir_we, pc_we});
      end
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got %b expected 0", fault);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cur_ir = ir;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    gen(16'h8542, 0, 3, -1);
    void'(q.pop_back());
    void'(q.pop_back());
    run_q("mid_mem_pre");
    reset_n = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({mem_req, rf_we, pc_we, ir_we} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_mem_reset req/rf_we/pc_we/ir_we got %b expected 0000", {mem_req, rf_we, pc_we, ir_we});
    end
    @(posedge clk); #1;
    reset_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, addr_sel, mem_we, mar_we, rf_we} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_mem_refetch req/asel/we/mar/rf got %b expected 10000",
               {mem_req, addr_sel, mem_we, mar_we, rf_we});
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_ld();
    test_st();
    test_back_to_back();
    test_random();
    test_halt();
    test_fault();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
